ext_state_restore: RTL

- Input-direction counterpart of the make_external "output" export: restores one exported register from a host beat stream.
- The host streams a register image in BEAT_WIDTH-bit beats. The block assembles the image, halts the user logic through a req/ack handshake, drives a one-cycle load strobe into the register's external input port, then releases the halt.
- It sits at the top level between the host link and the external "input" port the make_external pass creates.

---
 rtl/ext_state_restore.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ext_state_restore.sv
// ext_state_restore: assembles a register image from a host beat stream,
// freezes the user logic via halt_req/halt_ack, strobes the image into the
// exported register's external input port, then releases the freeze.
module ext_state_restore #(
  parameter int DATA_WIDTH = 32,
  parameter int BEAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BEAT_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  halt_req,
  input  logic                  halt_ack,
  output logic                  load_en,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, RECV, DRAIN, HALT, LOAD, RELEASE
  } state_t;

  state_t                             state, state_nx;
  logic [CW-1:0]                      cnt, cnt_nx;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   img;
  logic                               wr_en, err_nx, done_nx, take;

  // Beat acceptance is only possible in the receive-side states; reset
  // masks s_ready so nothing is consumed while rst is held.
  assign s_ready = !rst && (state == IDLE || state == RECV || state == DRAIN);
  assign busy    = (state != IDLE);
  assign take    = s_valid && s_ready;

  // Next-state decode; cnt always returns to 0 when leaving the receive
  // path so IDLE writes slice 0 with the same index logic as RECV.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_en    = 1'b0;
    err_nx   = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: if (take) begin
        wr_en = 1'b1;
        if (BEATS == 1) begin
          cnt_nx   = '0;
          state_nx = s_last ? HALT : DRAIN;
        end else if (s_last) begin
          cnt_nx   = '0;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx   = CW'(1);
          state_nx = RECV;
        end
      end
      RECV: if (take) begin
        wr_en = 1'b1;
        if (cnt == LAST_IDX) begin
          cnt_nx   = '0;
          state_nx = s_last ? HALT : DRAIN;
        end else if (s_last) begin
          cnt_nx   = '0;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DRAIN: if (take && s_last) begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
      HALT:    if (halt_ack) state_nx = LOAD;
      LOAD:    state_nx = RELEASE;
      RELEASE: if (!halt_ack) begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, beat counter and assembled image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      img   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (wr_en) img[cnt] <= s_data;
    end
  end

  // Registered outputs, decoded from the upcoming state so they line up
  // with the state they belong to; load_data only moves on entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_req  <= 1'b0;
      load_en   <= 1'b0;
      load_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      halt_req <= (state_nx == HALT) || (state_nx == LOAD);
      load_en  <= (state_nx == LOAD);
      if (state_nx == LOAD) load_data <= img;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule
